// File: rtl/frac_clken_gen_if.sv
// Configuration handshake bundle for the fractional clock-enable generator.
interface frac_clken_gen_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned ACC_W  = 16
);
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [ACC_W-1:0] cfg_num;
  logic [ACC_W-1:0] cfg_den;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_num, cfg_den,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_num, cfg_den,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator: each channel strobes at
// an average rate of refclk*NUM/DEN, all channels realigned after a reconfig.
module frac_clken_gen #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned ACC_W       = 16,
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              run,
  frac_clken_gen_if.slave   cfg,
  output logic [NUM_CH-1:0] clk_en,
  output logic              locked
);
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED, APPLY} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [NUM_CH-1:0] clk_en_q;
  logic              locked_q;
  logic              cfg_err_q;
  logic              cfg_ready_q;

  logic [ACC_W-1:0]  num_q [NUM_CH];
  logic [ACC_W-1:0]  den_q [NUM_CH];
  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [ACC_W-1:0]  acc_d [NUM_CH];
  logic [NUM_CH-1:0] hit_d;

  logic cfg_acc_c;
  logic cfg_ok_c;

  // Handshake qualification and request validity.
  always_comb begin
    cfg_acc_c = cfg.cfg_valid & cfg_ready_q;
    cfg_ok_c  = (cfg.cfg_den != '0) && (cfg.cfg_num <= cfg.cfg_den) &&
                ({1'b0, cfg.cfg_ch} < (CH_W+1)'(NUM_CH));
  end

  // Per-channel phase step: wrap by DEN and strobe on every wrap.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      logic [ACC_W:0] sum;
      sum = {1'b0, acc_q[i]} + {1'b0, num_q[i]};
      if (sum >= {1'b0, den_q[i]}) begin
        acc_d[i] = ACC_W'(sum - {1'b0, den_q[i]});
        hit_d[i] = 1'b1;
      end else begin
        acc_d[i] = sum[ACC_W-1:0];
        hit_d[i] = 1'b0;
      end
    end
  end

  // Control FSM, ratio registers, accumulators and registered outputs.
  // Ratios are written at acceptance; APPLY only realigns the accumulators,
  // which do not advance during APPLY, so the visible effect is identical.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      clk_en_q    <= '0;
      locked_q    <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        num_q[i] <= '0;
        den_q[i] <= ACC_W'(1);
        acc_q[i] <= '0;
      end
    end else begin
      cfg_err_q <= cfg_acc_c & ~cfg_ok_c;

      if (cfg_acc_c && cfg_ok_c) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (cfg.cfg_ch == CH_W'(i)) begin
            num_q[i] <= cfg.cfg_num;
            den_q[i] <= cfg.cfg_den;
          end
        end
      end

      if (!run) begin
        state_q     <= IDLE;
        cnt_q       <= '0;
        clk_en_q    <= '0;
        locked_q    <= 1'b0;
        cfg_ready_q <= 1'b1;
        for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            clk_en_q    <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
          end
          SETTLE: begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
            clk_en_q <= hit_d;
            cnt_q    <= cnt_q + CNT_W'(1);
            if (cfg_acc_c && cfg_ok_c) begin
              state_q     <= APPLY;
              cfg_ready_q <= 1'b0;
            end else if (cnt_q == CNT_W'(LOCK_CYCLES - 1)) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
            end
          end
          LOCKED: begin
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= acc_d[i];
            clk_en_q <= hit_d;
            if (cfg_acc_c && cfg_ok_c) begin
              state_q     <= APPLY;
              cfg_ready_q <= 1'b0;
              locked_q    <= 1'b0;
            end
          end
          default: begin
            state_q     <= SETTLE;
            cnt_q       <= '0;
            clk_en_q    <= '0;
            locked_q    <= 1'b0;
            cfg_ready_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
          end
        endcase
      end
    end
  end

  assign clk_en        = clk_en_q;
  assign locked        = locked_q;
  assign cfg.cfg_err   = cfg_err_q;
  assign cfg.cfg_ready = cfg_ready_q;
endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen: rates, latency, validation, realign, run/rst priority.
module tb_frac_clken_gen;
  logic       refclk;
  logic       rst;
  logic       run;
  logic [2:0] clk_en;
  logic       locked;

  int n_chk;
  int n_fail;

  frac_clken_gen_if #(.NUM_CH(3), .ACC_W(16)) cfg_if ();

  frac_clken_gen #(.NUM_CH(3), .ACC_W(16), .LOCK_CYCLES(64)) dut (
    .refclk (refclk),
    .rst    (rst),
    .run    (run),
    .cfg    (cfg_if),
    .clk_en (clk_en),
    .locked (locked)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One handshake; waits (bounded) for ready, then commits one edge.
  task automatic send_cfg(input logic [1:0] ch, input logic [15:0] num, input logic [15:0] den);
    int w;
    w = 0;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = ch;
    cfg_if.cfg_num   = num;
    cfg_if.cfg_den   = den;
    while (cfg_if.cfg_ready !== 1'b1 && w < 10) begin
      tick;
      w++;
    end
    chk("cfg_ready_wait", 32'(cfg_if.cfg_ready), 32'd1);
    tick;
    cfg_if.cfg_valid = 1'b0;
  endtask

  // Observe n cycles: strobe counts, first-strobe index, lock rise index, error pulses.
  task automatic window(input int n, output int c0, output int c1, output int c2,
                        output int f0, output int f1, output int f2,
                        output int lk, output int errs);
    c0 = 0; c1 = 0; c2 = 0; f0 = 0; f1 = 0; f2 = 0; lk = 0; errs = 0;
    for (int i = 1; i <= n; i++) begin
      tick;
      if (clk_en[0]) begin c0++; if (f0 == 0) f0 = i; end
      if (clk_en[1]) begin c1++; if (f1 == 0) f1 = i; end
      if (clk_en[2]) begin c2++; if (f2 == 0) f2 = i; end
      if (locked && lk == 0) lk = i;
      if (cfg_if.cfg_err) errs++;
    end
  endtask

  initial begin
    int c0, c1, c2, f0, f1, f2, lk, errs, mism;
    logic pat [1300];
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    run = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = '0;
    cfg_if.cfg_num   = '0;
    cfg_if.cfg_den   = '0;

    // Reset values
    tick; tick;
    chk("rst_clk_en", 32'(clk_en), 32'd0);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_cfg_err", 32'(cfg_if.cfg_err), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst = 1'b0;
    tick;

    // 1: rates 3/13, 6/25, 1/1 over 1300 locked cycles
    send_cfg(2'd0, 16'd3, 16'd13);
    chk("t1_cfg_err0", 32'(cfg_if.cfg_err), 32'd0);
    send_cfg(2'd1, 16'd6, 16'd25);
    send_cfg(2'd2, 16'd1, 16'd1);
    run = 1'b1;
    tick;
    window(64, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t1_lock_at", 32'(lk), 32'd64);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 1300; i++) begin
      pat[i] = clk_en[0];
      if (clk_en[0]) c0++;
      if (clk_en[1]) c1++;
      if (clk_en[2]) c2++;
      tick;
    end
    chk("t1_ch0_cnt", 32'(c0), 32'd300);
    chk("t1_ch1_cnt", 32'(c1), 32'd312);
    chk("t1_ch2_cnt", 32'(c2), 32'd1300);
    mism = 0;
    for (int j = 13; j < 1300; j++) if (pat[j] !== pat[j-13]) mism++;
    chk("t1_ch0_period13", 32'(mism), 32'd0);

    // 2: ch0 1/4, run rises at T
    run = 1'b0;
    tick;
    chk("t2_idle_clk_en", 32'(clk_en), 32'd0);
    chk("t2_idle_locked", 32'(locked), 32'd0);
    send_cfg(2'd0, 16'd1, 16'd4);
    run = 1'b1;
    tick;
    window(64, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t2_ch0_first", 32'(f0), 32'd4);
    chk("t2_ch0_cnt", 32'(c0), 32'd16);
    chk("t2_ch1_cnt", 32'(c1), 32'd15);
    chk("t2_ch2_cnt", 32'(c2), 32'd64);
    chk("t2_lock_at", 32'(lk), 32'd64);
    chk("t2_no_err", 32'(errs), 32'd0);

    // 3: rejected configs in LOCKED
    send_cfg(2'd0, 16'd0, 16'd0);
    chk("t3a_err", 32'(cfg_if.cfg_err), 32'd1);
    chk("t3a_locked", 32'(locked), 32'd1);
    tick;
    chk("t3a_err_once", 32'(cfg_if.cfg_err), 32'd0);
    send_cfg(2'd1, 16'd5, 16'd4);
    chk("t3b_err", 32'(cfg_if.cfg_err), 32'd1);
    chk("t3b_ready", 32'(cfg_if.cfg_ready), 32'd1);
    tick;
    chk("t3b_err_once", 32'(cfg_if.cfg_err), 32'd0);
    send_cfg(2'd3, 16'd1, 16'd2);
    chk("t3c_err", 32'(cfg_if.cfg_err), 32'd1);
    tick;
    chk("t3c_err_once", 32'(cfg_if.cfg_err), 32'd0);
    window(100, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t3_ch0_cnt", 32'(c0), 32'd25);
    chk("t3_ch1_cnt", 32'(c1), 32'd24);
    chk("t3_ch2_cnt", 32'(c2), 32'd100);
    chk("t3_locked", 32'(locked), 32'd1);

    // 4: valid reconfig while LOCKED (ch1 -> 1/5)
    send_cfg(2'd1, 16'd1, 16'd5);
    chk("t4_ready_low", 32'(cfg_if.cfg_ready), 32'd0);
    chk("t4_locked_fall", 32'(locked), 32'd0);
    tick;
    chk("t4_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
    chk("t4_clk_en_gap", 32'(clk_en), 32'd0);
    window(64, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t4_ch0_first", 32'(f0), 32'd4);
    chk("t4_ch1_first", 32'(f1), 32'd5);
    chk("t4_ch2_first", 32'(f2), 32'd1);
    chk("t4_ch1_cnt", 32'(c1), 32'd12);
    chk("t4_lock_at", 32'(lk), 32'd64);

    // 5: run falls at settle counter 20 together with a cfg accept
    send_cfg(2'd0, 16'd1, 16'd3);
    tick;
    for (int i = 0; i < 20; i++) tick;
    run = 1'b0;
    send_cfg(2'd0, 16'd2, 16'd7);
    chk("t5_clk_en", 32'(clk_en), 32'd0);
    chk("t5_locked", 32'(locked), 32'd0);
    chk("t5_ready", 32'(cfg_if.cfg_ready), 32'd1);
    chk("t5_err", 32'(cfg_if.cfg_err), 32'd0);
    run = 1'b1;
    tick;
    window(70, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t5_ch0_first", 32'(f0), 32'd4);
    chk("t5_ch0_cnt", 32'(c0), 32'd20);

    // 6: rst while LOCKED with strobes active
    chk("t6_pre_locked", 32'(locked), 32'd1);
    chk("t6_pre_ch2", 32'(clk_en[2]), 32'd1);
    rst = 1'b1;
    tick;
    chk("t6_clk_en", 32'(clk_en), 32'd0);
    chk("t6_locked", 32'(locked), 32'd0);
    chk("t6_err", 32'(cfg_if.cfg_err), 32'd0);
    chk("t6_ready", 32'(cfg_if.cfg_ready), 32'd1);
    rst = 1'b0;
    window(100, c0, c1, c2, f0, f1, f2, lk, errs);
    chk("t6_no_strobes", 32'(c0 + c1 + c2), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
